// File: rtl/muldiv_unit.sv
// Multi-cycle MULTU/DIVU unit with architectural HI/LO registers and pipeline stall.
// Define MULDIV_SIGNED_EN to add the sgn input (signed MULT/DIV).
//   state | meaning
//   IDLE  | accepting start, MTHI/MTLO writes
//   MUL   | shift-add, one multiplier bit per cycle
//   DIV   | restoring divide, one quotient bit per cycle
//   FIN   | commit HI/LO, pulse done
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               op_q;
  logic               dz;
  logic               neg_p;
  logic               neg_r;
  logic               sgn_eff;

`ifdef MULDIV_SIGNED_EN
  assign sgn_eff = sgn;
`else
  assign sgn_eff = 1'b0;
`endif

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   rsh;
  logic [WIDTH+1:0]   rdiff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    a_mag    = (sgn_eff && a[WIDTH-1]) ? -a : a;
    b_mag    = (sgn_eff && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
    // remainder stays below the divisor, so the top bit of the difference is the borrow
    rsh      = {rem, acc[WIDTH-1]};
    rdiff    = rsh - {2'b00, opb};
    q_bit    = ~rdiff[WIDTH+1];
    prod_fix = neg_p ? -acc : acc;
    q_fix    = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy & (rd_req | start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      a_raw <= '0;
      acc   <= '0;
      rem   <= '0;
      op_q  <= 1'b0;
      dz    <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi <= wd;
          if (wr_lo) lo <= wd;
          if (start) begin
            cnt   <= '0;
            rem   <= '0;
            op_q  <= op;
            a_raw <= a;
            dz    <= op && (b == '0);
            neg_p <= sgn_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn_eff & a[WIDTH-1];
            opb   <= b_mag;
            if (!op) begin
              opa   <= a_mag;
              acc   <= '0;
              state <= S_MUL;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              state <= (b == '0) ? S_FIN : S_DIV;
            end
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIN;
        end
        S_DIV: begin
          rem <= q_bit ? rdiff[WIDTH:0] : rsh[WIDTH:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIN;
        end
        default: begin
          if (dz) begin
            hi <= a_raw;
            lo <= '1;
          end else if (!op_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes arithmetic-model results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op, rd_req, wr_hi, wr_lo;
  logic [W-1:0] a, b, wd;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
`ifdef MULDIV_SIGNED_EN
    .sgn(1'b0),
`endif
    .a(a), .b(b), .rd_req(rd_req), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  logic rst_edge = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic; done seen at the negedge after E33 (E1 for divide-by-zero).
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int c);
    exp_t e;
    logic [2*W-1:0] p;
    if (!o) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.cyc = c + W + 2;
    end else if (y == 0) begin
      e.hi = x;
      e.lo = '1;
      e.cyc = c + 2;
    end else begin
      e.lo = x / y;
      e.hi = x % y;
      e.cyc = c + W + 2;
    end
    return e;
  endfunction

  // Monitor
  logic [W-1:0] prev_hi = '0, prev_lo = '0;
  logic         prev_busy = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
          chk("done_cycle", W'(cyc), W'(e.cyc));
        end
        chk("done_single_pulse", {31'b0, prev_done}, 32'd0);
      end
      if (prev_busy && !done && !rst_edge) begin
        chk("hi_held_while_busy", hi, prev_hi);
        chk("lo_held_while_busy", lo, prev_lo);
      end
    end
    prev_hi   = hi;
    prev_lo   = lo;
    prev_busy = busy;
    prev_done = done;
  end

  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit track);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (track) q.push_back(model(o, x, y, cyc));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle_timeout: got busy=1 after 100 cycles expected busy=0");
  endtask

  task automatic mt(input bit sel_hi, input logic [W-1:0] d);
    @(negedge clk);
    wd = d;
    if (sel_hi) wr_hi = 1'b1; else wr_lo = 1'b1;
    @(posedge clk);
    #1 wr_hi = 1'b0; wr_lo = 1'b0;
    @(negedge clk);
    if (sel_hi) chk("mthi", hi, d); else chk("mtlo", lo, d);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    finish_run();
  end

  initial begin
    int n;
    logic         o;
    logic [W-1:0] x, y;
    bit           accepted;

    rst = 1'b1; start = 0; op = 0; a = '0; b = '0; rd_req = 0; wr_hi = 0; wr_lo = 0; wd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    mon_en = 1;

    // MULTU max * max, busy for 33 cycles
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle(n);
    chk("mul_busy_cycles", W'(n), 32'd33);
    chk("mul_max_hi", hi, 32'hFFFF_FFFE);
    chk("mul_max_lo", lo, 32'h0000_0001);

    issue(1'b1, 32'd100, 32'd7, 1);
    wait_idle(n);
    chk("div_busy_cycles", W'(n), 32'd33);

    issue(1'b1, 32'h1234_5678, 32'd0, 1);
    wait_idle(n);
    chk("div0_busy_cycles", W'(n), 32'd1);

    // MULTU 3*5 with MFLO waiting
    issue(1'b0, 32'd3, 32'd5, 1);
    rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("stall_rd_req", {31'b0, stall}, 32'd1);
    end
    chk("unstalled_read_stall", {31'b0, stall}, 32'd0);
    chk("unstalled_read_lo", lo, 32'd15);
    chk("unstalled_read_hi", hi, 32'd0);
    rd_req = 1'b0;

    // second start while busy: stalled, ignored, accepted once idle
    issue(1'b0, 32'd6, 32'd7, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd2;
    accepted = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!busy) begin
        accepted = 1;
        break;
      end
      chk("stall_second_start", {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL second_start_timeout: got busy=1 expected idle");
    end
    q.push_back(model(1'b1, 32'd9, 32'd2, cyc));
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(n);
    chk("reissued_div_lo", lo, 32'd4);
    chk("reissued_div_hi", hi, 32'd1);

    // reset in the middle of a MULTU: no commit, no done
    issue(1'b0, 32'h0000_1234, 32'h0000_5678, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (40) @(negedge clk);

    mt(1'b1, 32'h0000_ABCD);
    mt(1'b0, 32'h1357_9BDF);

    // MTLO and start in the same idle cycle: write lands, commit later overwrites
    @(negedge clk);
    wr_lo = 1'b1; wd = 32'h5A5A_5A5A;
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd3;
    q.push_back(model(1'b0, 32'd2, 32'd3, cyc));
    @(posedge clk);
    #1 start = 1'b0; wr_lo = 1'b0;
    @(negedge clk);
    chk("write_before_start_lo", lo, 32'h5A5A_5A5A);
    wait_idle(n);
    chk("commit_overwrites_lo", lo, 32'd6);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 20));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) x = W'($urandom_range(0, 50));
      if ($urandom_range(0, 2) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(o, x, y, 1);
      wait_idle(n);
      chk("rand_busy_cycles", W'(n), (o && y == '0) ? 32'd1 : 32'd33);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    finish_run();
  end

endmodule
